// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller that tracks in-flight destinations after decode.
// Optional macro PIPE_HAZARD_ZERO_REG_EN hardwires register 0 to zero.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 3,
  parameter int NUM_SRC    = 2,
  parameter int REG_ADDR_W = 4,
  parameter int LOAD_STAGE = 3,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = $clog2(NUM_STAGES+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_dst_addr,
  input  logic                          id_dst_wr,
  input  logic                          id_is_load,
  input  logic                          id_halt,
  input  logic                          id_flush,
  output logic                          issue,
  output logic                          stall,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          halt_sys,
  output logic                          busy,
  output logic [CNT_W-1:0]              perf_stall_cnt
);

  if (LOAD_STAGE < 1 || LOAD_STAGE > NUM_STAGES) begin : g_bad_load_stage
    $error("pipe_hazard_ctrl: LOAD_STAGE must be in 1..NUM_STAGES");
  end

`ifdef PIPE_HAZARD_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef struct packed {
    logic                  v;
    logic                  wr;
    logic [REG_ADDR_W-1:0] dst;
    logic                  ld;
    logic                  hlt;
  } entry_t;

  entry_t ent [1:NUM_STAGES];
  entry_t new_ent;

  logic                     halt_pend;
  logic [NUM_SRC-1:0]       src_req;
  logic [NUM_SRC-1:0]       src_stall;
  logic [NUM_SRC*SEL_W-1:0] sel_raw;
  logic                     stall_raw;
  logic                     busy_raw;

  always_comb begin
    src_req = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_req[i] = id_valid && id_src_used[i] &&
        !(ZERO_REG && id_src_addr[i*REG_ADDR_W +: REG_ADDR_W] == '0);
    end
  end

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    src_stall = '0;
    sel_raw   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_STAGES; k >= 1; k--) begin
        if (src_req[i] && ent[k].v && ent[k].wr &&
            ent[k].dst == id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]) begin
          src_stall[i] = ent[k].ld && (k < LOAD_STAGE);
          sel_raw[i*SEL_W +: SEL_W] =
            (ent[k].ld && (k < LOAD_STAGE)) ? '0 : SEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    busy_raw = 1'b0;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      busy_raw = busy_raw | ent[k].v;
    end
  end

  assign stall_raw = id_valid && (|src_stall);
  assign stall     = !rst && stall_raw;
  assign fwd_sel   = rst ? '0 : sel_raw;
  assign busy      = !rst && busy_raw;
  assign issue     = !rst && id_valid && !stall_raw && !id_flush &&
                     !halt_pend && !halt_sys;

  always_comb begin
    new_ent     = '0;
    new_ent.v   = 1'b1;
    new_ent.wr  = id_dst_wr && !(ZERO_REG && id_dst_addr == '0);
    new_ent.dst = id_dst_addr;
    new_ent.ld  = id_is_load;
    new_ent.hlt = id_halt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        ent[k] <= '0;
      end
      halt_pend      <= 1'b0;
      halt_sys       <= 1'b0;
      perf_stall_cnt <= '0;
    end else begin
      ent[1] <= issue ? new_ent : '0;
      for (int k = 2; k <= NUM_STAGES; k++) begin
        ent[k] <= ent[k-1];
      end
      if (issue && id_halt) begin
        halt_pend <= 1'b1;
      end
      if (ent[NUM_STAGES].v && ent[NUM_STAGES].hlt) begin
        halt_sys <= 1'b1;
      end
      if (stall && !(&perf_stall_cnt)) begin
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl against an issue-history reference model.
// Directed scenarios first, then randomized traffic with occasional resets.
module tb_pipe_hazard_ctrl;

  localparam int NS   = 3;
  localparam int NSRC = 2;
  localparam int AW   = 4;
  localparam int LS   = 3;
  localparam int CW   = 5;
  localparam int SW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, id_valid, id_dst_wr, id_is_load, id_halt, id_flush;
  logic [NSRC*AW-1:0] id_src_addr;
  logic [NSRC-1:0]    id_src_used;
  logic [AW-1:0]      id_dst_addr;
  logic               issue, stall, halt_sys, busy;
  logic [NSRC*SW-1:0] fwd_sel;
  logic [CW-1:0]      perf_stall_cnt;

  pipe_hazard_ctrl #(
    .NUM_STAGES(NS), .NUM_SRC(NSRC), .REG_ADDR_W(AW),
    .LOAD_STAGE(LS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_dst_addr(id_dst_addr), .id_dst_wr(id_dst_wr),
    .id_is_load(id_is_load), .id_halt(id_halt), .id_flush(id_flush),
    .issue(issue), .stall(stall), .fwd_sel(fwd_sel),
    .halt_sys(halt_sys), .busy(busy), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, valid, wr, ld, hlt, flush;
    logic [AW-1:0] s0, s1, dst;
    logic [1:0] used;
  } in_t;

  typedef struct {
    int t;
    bit wr, ld, hlt;
    logic [AW-1:0] dst;
  } rec_t;

  typedef struct {
    bit issue, stall, busy, halt_sys, chk;
    logic [NSRC*SW-1:0] fwd;
    logic [CW-1:0] cnt;
  } exp_t;

  rec_t recs[$];
  exp_t sbq[$];
  int cyc = 0;
  bit hpend = 0, hflag = 0, known = 0;
  int cnt_m = 0;
  int checks = 0, errors = 0;

  function automatic bit is_zero_reg(logic [AW-1:0] a);
`ifdef PIPE_HAZARD_ZERO_REG_EN
    return a == '0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t predict(in_t in);
    exp_t e;
    logic [AW-1:0] a;
    int best, age;
    bit bld;
    e = '{default: 0};
    for (int i = 0; i < NSRC; i++) begin
      a = (i == 0) ? in.s0 : in.s1;
      best = 0;
      bld = 0;
      if (in.valid && in.used[i] && !is_zero_reg(a)) begin
        foreach (recs[j]) begin
          age = cyc - recs[j].t;
          if (age >= 1 && age <= NS && recs[j].wr && recs[j].dst == a &&
              (best == 0 || age < best)) begin
            best = age;
            bld = recs[j].ld;
          end
        end
      end
      if (best != 0) begin
        if (bld && best < LS) e.stall = 1;
        else e.fwd[i*SW +: SW] = SW'(best);
      end
    end
    foreach (recs[j]) begin
      age = cyc - recs[j].t;
      if (age >= 1 && age <= NS) e.busy = 1;
    end
    e.issue = in.valid && !e.stall && !in.flush && !hpend && !hflag;
    e.halt_sys = hflag;
    e.cnt = CW'(cnt_m);
    e.chk = known;
    if (in.rst) begin
      e.issue = 0;
      e.stall = 0;
      e.fwd = '0;
      e.busy = 0;
    end
    return e;
  endfunction

  task automatic cycle(input in_t in);
    exp_t e;
    rst = in.rst;
    id_valid = in.valid;
    id_src_addr = {in.s1, in.s0};
    id_src_used = in.used;
    id_dst_addr = in.dst;
    id_dst_wr = in.wr;
    id_is_load = in.ld;
    id_halt = in.hlt;
    id_flush = in.flush;
    e = predict(in);
    sbq.push_back(e);
    @(posedge clk);
    if (in.rst) begin
      recs.delete();
      hpend = 0;
      hflag = 0;
      cnt_m = 0;
      known = 1;
    end else begin
      if (e.issue)
        recs.push_back('{cyc, in.wr && !is_zero_reg(in.dst),
                         in.ld, in.hlt, in.dst});
      if (e.issue && in.hlt) hpend = 1;
      if (e.stall && cnt_m < CMAX) cnt_m++;
    end
    cyc++;
    while (recs.size() > 0 && cyc - recs[0].t > NS) begin
      if (recs[0].hlt) hflag = 1;
      void'(recs.pop_front());
    end
    #1;
  endtask

  function automatic in_t mk(bit v, int s0, int s1, bit [1:0] u, int d,
                             bit wr, bit ld = 0, bit hlt = 0,
                             bit fl = 0, bit r = 0);
    in_t x;
    x.valid = v;
    x.s0 = AW'(s0);
    x.s1 = AW'(s1);
    x.used = u;
    x.dst = AW'(d);
    x.wr = wr;
    x.ld = ld;
    x.hlt = hlt;
    x.flush = fl;
    x.rst = r;
    return x;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", n, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("issue", 32'(issue), 32'(e.issue));
      chk("stall", 32'(stall), 32'(e.stall));
      chk("fwd_sel", 32'(fwd_sel), 32'(e.fwd));
      chk("busy", 32'(busy), 32'(e.busy));
      if (e.chk) begin
        chk("halt_sys", 32'(halt_sys), 32'(e.halt_sys));
        chk("perf_stall_cnt", 32'(perf_stall_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    in_t r;
    @(posedge clk);
    #1;
    // reset with valid decode
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // ALU forward distances 1..4
    cycle(mk(1, 1, 2, 3, 3, 1));
    repeat (4) cycle(mk(1, 3, 4, 3, 0, 0));
    // load-use held consumer
    cycle(mk(1, 0, 0, 0, 5, 1, 1));
    repeat (3) cycle(mk(1, 5, 6, 3, 7, 1));
    // youngest match wins
    cycle(mk(1, 0, 0, 0, 2, 1));
    cycle(mk(1, 0, 0, 0, 2, 1));
    cycle(mk(1, 2, 2, 3, 0, 0));
    // flush leaves a bubble
    cycle(mk(1, 0, 0, 0, 9, 1, 0, 0, 1));
    cycle(mk(1, 9, 9, 3, 0, 0));
    // flush together with stall
    cycle(mk(1, 0, 0, 0, 6, 1, 1));
    cycle(mk(1, 6, 0, 1, 0, 0, 0, 0, 1));
    repeat (3) cycle(mk(1, 6, 0, 1, 0, 0));
    // load to r0 then consumer of r0
    cycle(mk(1, 0, 0, 0, 0, 1, 1));
    repeat (3) cycle(mk(1, 0, 0, 3, 1, 1));
    // halt then held traffic
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 1));
    repeat (6) cycle(mk(1, 1, 1, 3, 1, 1));
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r.valid = ($urandom % 8) != 0;
      r.s0 = AW'($urandom % 8);
      r.s1 = AW'($urandom % 8);
      r.used = 2'($urandom);
      r.dst = AW'($urandom % 8);
      r.wr = ($urandom % 4) != 0;
      r.ld = ($urandom % 3) == 0;
      r.hlt = ($urandom % 150) == 0;
      r.flush = ($urandom % 12) == 0;
      r.rst = ($urandom % 120) == 0;
      cycle(r);
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
